div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit; reset is asynchronous and active-low.
REQ-003 SHALL have port es_to_div_bus, input, `ES_TO_DIV_BUS_MD (67) bits; packing MSB to LSB: {div_en, use_mod, is_unsigned, src1[31:0], src2[31:0]}; src1 is the dividend, src2 the divisor.
REQ-004 SHALL have port div_to_es_bus, output, `DIV_TO_ES_BUS_MD (33) bits; packing MSB to LSB: {div_result[31:0], div_ok}.
REQ-005 SHALL provide parameter DIV_CYCLES, default 32; it is the number of iteration cycles, one quotient bit per cycle.

Function
REQ-006 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-007 IDLE with div_en=1 SHALL, in that cycle T:
- latch use_mod, is_unsigned and the operand signs;
- latch |src1| and |src2|, or raw values when is_unsigned=1;
- clear the partial remainder;
- load the iteration counter with DIV_CYCLES-1;
- go to BUSY.
REQ-008 IDLE with div_en=0 SHALL hold IDLE, with no register update other than the state.
REQ-009 Each BUSY cycle SHALL perform one restoring radix-2 step and decrement the counter; BUSY SHALL go to DONE when the counter is 0.
REQ-010 A restoring step SHALL:
- shift the partial remainder left one bit, bringing in the next dividend MSB;
- subtract the divisor using 33-bit arithmetic;
- on a non-negative difference, keep the difference and set the quotient bit to 1;
- otherwise, keep the shifted remainder and set the quotient bit to 0.
REQ-011 div_ok SHALL be 1 only in DONE, and DONE SHALL last exactly one cycle then return to IDLE; for an accept at T, div_ok=1 at T+DIV_CYCLES+1 (T+33).
REQ-012 In DONE, div_result SHALL be the quotient when use_mod=0 and the remainder when use_mod=1; in every other state div_result SHALL be 0.
REQ-013 The signed result SHALL be formed in the DONE cycle from the latched signs, not from the live bus:
- quotient sign = sign(src1) XOR sign(src2);
- remainder sign = sign(src1);
- the result is negated in two's complement as required.
REQ-014 Division by zero SHALL use the normal fixed latency and SHALL return quotient 0xFFFFFFFF (unsigned) or the natural restoring-algorithm result (signed), and remainder = src1 unchanged, with no exception signalled.
REQ-015 Signed 0x80000000 / 0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0.
REQ-016 div_en=0 in any BUSY cycle SHALL abort the operation: next state IDLE, and no div_ok for the aborted operation (pipeline flush or stage exit).
REQ-017 Operand changes on the bus while BUSY SHALL be ignored; only latched values are used.
REQ-018 div_en=1 in the DONE cycle SHALL NOT start a new operation; a new operation SHALL start on the following IDLE cycle, which is the back-to-back case where the issuing stage advances on div_ok.
REQ-019 Back-to-back operations SHALL therefore have accepts DIV_CYCLES+2 cycles apart (34).

Reset
REQ-020 resetn=0 SHALL asynchronously force: state=IDLE, counter=0, remainder/quotient/operand registers=0, div_ok=0, div_result=0.
REQ-021 Reset asserted mid-BUSY SHALL discard the operation; the first div_en=1 in IDLE after release SHALL start a fresh operation with full latency.

Structure
REQ-022 Bus widths `ES_TO_DIV_BUS_MD=67 and `DIV_TO_ES_BUS_MD=33 SHALL reside in the shared define.vh with the other stage-bus widths.
REQ-023 The FSM state encodings (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) SHALL be localparams inside div_unit, not shared.
REQ-024 The combinational restoring step (remainder, divisor -> next remainder, quotient bit) SHALL be the single sub-module div_step.

Verification
REQ-025 Unsigned: src1=100, src2=7, div_en held high from T -> div_ok=1 only at T+33, result 14 (use_mod=0) and 2 (use_mod=1).
REQ-026 Signed: -7/2 -> quotient 0xFFFFFFFD (-3); -7 mod 2 -> 0xFFFFFFFF (-1); 7 mod -2 -> 1; 0x80000000/0xFFFFFFFF -> 0x80000000, mod -> 0.
REQ-027 Divide by zero: unsigned 0x12345678/0 -> quotient 0xFFFFFFFF, mod 0x12345678, div_ok at T+33.
REQ-028 Abort: div_en dropped at T+10 -> div_ok stays 0 through T+40; a new request at T+12 returns its own result at T+45.
REQ-029 Back-to-back: div_en held high across two operations with changed operands -> div_ok at T+33 and T+67 with the correct results; operands altered at T+5 do not affect the first result.
REQ-030 Reset: resetn pulled low asynchronously (between clock edges) at T+20 -> div_ok=0 and div_result=0 immediately; after release a request completes in 33 cycles.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared stage-bus widths and the execute-to-divider request layout.
// Included first so the width macros are visible to every later file.
`ifndef ES_TO_DIV_BUS_MD
`define ES_TO_DIV_BUS_MD 67
`endif
`ifndef DIV_TO_ES_BUS_MD
`define DIV_TO_ES_BUS_MD 33
`endif

package div_unit_pkg;

  localparam int ES_TO_DIV_W = `ES_TO_DIV_BUS_MD;
  localparam int DIV_TO_ES_W = `DIV_TO_ES_BUS_MD;

  typedef struct packed {
    logic        div_en;
    logic        use_mod;
    logic        is_unsigned;
    logic [31:0] src1;
    logic [31:0] src2;
  } es_to_div_t;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 step: shift in a dividend bit, trial-subtract the divisor.
module div_step (
  input  logic [31:0] i_rem,
  input  logic        i_dvd_bit,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_rem,
  output logic        o_qbit
);

  logic [32:0] w_shifted;
  logic [32:0] w_diff;

  assign w_shifted = {i_rem, i_dvd_bit};
  assign w_diff    = w_shifted - {1'b0, i_divisor};

  // A set bit 32 means the trial difference went negative, so restore.
  assign o_qbit = ~w_diff[32];
  assign o_rem  = o_qbit ? w_diff[31:0] : w_shifted[31:0];

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider, one quotient bit per cycle.
// Result and div_ok are presented only during the single DONE cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [ES_TO_DIV_W-1:0] es_to_div_bus,
  output logic [DIV_TO_ES_W-1:0] div_to_es_bus
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;
  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    BUSY = S_BUSY,
    DONE = S_DONE
  } state_e;

  es_to_div_t  w_req;
  state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_dvd;
  logic [31:0] r_dsr;
  logic [31:0] r_quot;
  logic        r_use_mod;
  logic        r_sign_q;
  logic        r_sign_r;

  logic        w_neg1;
  logic        w_neg2;
  logic [31:0] w_step_rem;
  logic        w_qbit;
  logic [31:0] w_result;

  assign w_req  = es_to_div_bus;
  assign w_neg1 = ~w_req.is_unsigned & w_req.src1[31];
  assign w_neg2 = ~w_req.is_unsigned & w_req.src2[31];

  div_step u_step (
    .i_rem     (r_rem),
    .i_dvd_bit (r_dvd[31]),
    .i_divisor (r_dsr),
    .o_rem     (w_step_rem),
    .o_qbit    (w_qbit)
  );

  // NOTE: non-blocking assignments everywhere below, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: the datapath registers are reset as well, so no stale operand survives a reset.
    if (!resetn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_dsr     <= '0;
      r_quot    <= '0;
      r_use_mod <= 1'b0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req.div_en) begin
            r_use_mod <= w_req.use_mod;
            r_sign_q  <= w_neg1 ^ w_neg2;
            r_sign_r  <= w_neg1;
            r_dvd     <= neg_if(w_req.src1, w_neg1);
            r_dsr     <= neg_if(w_req.src2, w_neg2);
            r_rem     <= '0;
            r_quot    <= '0;
            r_cnt     <= CNT_LOAD;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          // Dropping div_en mid-operation is a flush from the issuing stage.
          if (!w_req.div_en) begin
            r_state <= IDLE;
          end else begin
            r_rem  <= w_step_rem;
            r_dvd  <= {r_dvd[30:0], 1'b0};
            r_quot <= {r_quot[30:0], w_qbit};
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == '0) r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_result = r_use_mod ? neg_if(r_rem, r_sign_r) : neg_if(r_quot, r_sign_q);

  assign div_to_es_bus = (r_state == DONE) ? {w_result, 1'b1} : '0;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, abort, back-to-back,
// asynchronous reset, and randomized operations against an arithmetic model.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk;
  logic        resetn;
  es_to_div_t  tb_req;
  logic [32:0] w_out;
  logic [31:0] w_res;
  logic        w_ok;

  int n_tests = 0;
  int n_fail  = 0;

  div_unit #(.DIV_CYCLES(32)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .es_to_div_bus (tb_req),
    .div_to_es_bus (w_out)
  );

  assign w_res = w_out[32:1];
  assign w_ok  = w_out[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero results the
  // restoring algorithm yields (all-ones magnitude quotient, dividend remainder).
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic mod, input logic uns);
    longint sa, sb, q, r;
    if (uns) begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    if (b == 32'd0) begin
      q = (!uns && a[31]) ? 64'sd1 : 64'sh0FFFFFFFF;
      r = sa;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return mod ? r[31:0] : q[31:0];
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic mod, input logic uns);
    tb_req.div_en      = 1'b1;
    tb_req.use_mod     = mod;
    tb_req.is_unsigned = uns;
    tb_req.src1        = a;
    tb_req.src2        = b;
  endtask

  // Counts negedges until div_ok, bounded; lat = -1 if it never arrives.
  task automatic wait_ok(input int mutate_at, output int lat, output logic [31:0] res);
    lat = -1;
    res = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == mutate_at) begin
        tb_req.src1 = $urandom;
        tb_req.src2 = $urandom;
      end
      if (w_ok) begin
        lat = i;
        res = w_res;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic mod, input logic uns, input logic [31:0] exp);
    int          lat;
    logic [31:0] res;
    drive(a, b, mod, uns);
    wait_ok(0, lat, res);
    check({tag, "_lat"}, lat, 33);
    check(tag, res, exp);
    tb_req.div_en = 1'b0;
    @(negedge clk);
    check({tag, "_after"}, w_out, 33'd0);
  endtask

  initial begin
    int          lat, first_ok;
    logic [31:0] res, a, b, exp;
    logic        mod, uns;

    tb_req = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_bus", w_out, 33'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_bus", w_out, 33'd0);

    run_op("u_100_div_7", 32'd100, 32'd7, 1'b0, 1'b1, 32'd14);
    run_op("u_100_mod_7", 32'd100, 32'd7, 1'b1, 1'b1, 32'd2);
    run_op("s_m7_div_2",  32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 32'hFFFFFFFD);
    run_op("s_m7_mod_2",  32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 32'hFFFFFFFF);
    run_op("s_7_mod_m2",  32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, 32'd1);
    run_op("s_min_div_m1", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h80000000);
    run_op("s_min_mod_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'd0);
    run_op("u_div0_q", 32'h12345678, 32'd0, 1'b0, 1'b1, 32'hFFFFFFFF);
    run_op("u_div0_r", 32'h12345678, 32'd0, 1'b1, 1'b1, 32'h12345678);

    // Back-to-back with operands disturbed mid-flight on the first operation.
    drive(32'd100, 32'd7, 1'b0, 1'b1);
    wait_ok(5, lat, res);
    check("b2b_first_lat", lat, 33);
    check("b2b_first_res", res, 32'd14);
    drive(32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    wait_ok(0, lat, res);
    check("b2b_second_lat", lat, 34);
    check("b2b_second_res", res, 32'hFFFFFFFD);
    tb_req.div_en = 1'b0;
    @(negedge clk);

    // Abort at T+10, new request at T+12 completes at T+45.
    drive(32'd100, 32'd7, 1'b0, 1'b1);
    first_ok = -1;
    res = '0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (w_ok && first_ok < 0) begin
        first_ok = c;
        res = w_res;
        tb_req.div_en = 1'b0;
      end
      if (c == 10) tb_req.div_en = 1'b0;
      if (c == 12) drive(32'd1000, 32'd3, 1'b1, 1'b1);
    end
    check("abort_ok_cycle", first_ok, 45);
    check("abort_new_res", res, 32'd1);

    // Asynchronous reset while DONE is on the bus.
    drive(32'd50, 32'd5, 1'b0, 1'b1);
    wait_ok(0, lat, res);
    check("rst_pre_res", res, 32'd10);
    #2 resetn = 1'b0;
    #1 check("rst_in_done_bus", w_out, 33'd0);
    tb_req.div_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Asynchronous reset mid-BUSY, then a fresh full-latency operation.
    drive(32'd99, 32'd9, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    #2 resetn = 1'b0;
    #1 check("rst_mid_busy_bus", w_out, 33'd0);
    @(negedge clk);
    tb_req.div_en = 1'b0;
    resetn = 1'b1;
    first_ok = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (w_ok) first_ok++;
    end
    check("rst_discarded_ok", first_ok, 0);
    run_op("rst_fresh_op", 32'd77, 32'd8, 1'b1, 1'b1, 32'd5);

    for (int k = 0; k < 16; k++) begin
      a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFFFFFF;
        3:       b = $urandom_range(1, 100);
        4:       b = $urandom >> 16;
        default: b = $urandom;
      endcase
      mod = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      exp = ref_div(a, b, mod, uns);
      run_op($sformatf("rand%0d", k), a, b, mod, uns, exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
